// File: rtl/exec_unit_pkg.sv
// Shared definitions for the execute/writeback stage and its RegisterFile neighbour.
package exec_unit_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_ID_W  = 4;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_ADD   = 4'd1;
   localparam logic [3:0] OP_SUB   = 4'd2;
   localparam logic [3:0] OP_AND   = 4'd3;
   localparam logic [3:0] OP_OR    = 4'd4;
   localparam logic [3:0] OP_XOR   = 4'd5;
   localparam logic [3:0] OP_SHL   = 4'd6;
   localparam logic [3:0] OP_SHR   = 4'd7;
   localparam logic [3:0] OP_PASSB = 4'd8;
   localparam logic [3:0] OP_MUL   = 4'd9;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   // Ops that finish through the combinational ALU in the accept cycle.
   function automatic logic is_single_op(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_PASSB);
   endfunction

endpackage

// File: rtl/exec_unit_if.sv
// Decode-side handshake plus RegisterFile write-port bundle for exec_unit.
interface exec_unit_if
   import exec_unit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ID_W  = DEF_ID_W
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [ID_W-1:0]  src1_id;
   logic [ID_W-1:0]  src2_id;
   logic [ID_W-1:0]  dst_id_in;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             wb_en;
   logic [ID_W-1:0]  wb_id;
   logic [WIDTH-1:0] wb_data;
   logic             flag_z;
   logic             flag_c;

   modport master (
      output in_valid, op, src1_id, src2_id, dst_id_in, a, b,
      input  in_ready, wb_en, wb_id, wb_data, flag_z, flag_c
   );

   modport slave (
      input  in_valid, op, src1_id, src2_id, dst_id_in, a, b,
      output in_ready, wb_en, wb_id, wb_data, flag_z, flag_c
   );
endinterface

// File: rtl/exec_alu.sv
// Combinational ALU for the single-cycle opcodes; MUL is handled by the sequencer.
module exec_alu
   import exec_unit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             carry
);
   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   // Result and carry/borrow selection by opcode
   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum[WIDTH-1:0];
            carry  = sum[WIDTH];
         end
         OP_SUB: begin
            result = diff[WIDTH-1:0];
            carry  = diff[WIDTH];
         end
         OP_AND:   result = a & b;
         OP_OR:    result = a | b;
         OP_XOR:   result = a ^ b;
         OP_SHL: begin
            result = {a[WIDTH-2:0], 1'b0};
            carry  = a[WIDTH-1];
         end
         OP_SHR: begin
            result = {1'b0, a[WIDTH-1:1]};
            carry  = a[0];
         end
         OP_PASSB: result = b;
         default: begin
            result = '0;
            carry  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/exec_unit.sv
// Execute/writeback stage: bypass mux, ALU, shift-add multiplier and RegisterFile write port.
//
// state   | meaning
// ST_IDLE | ready for an op; single-cycle ops write back on the accept edge
// ST_MUL  | shift-add multiply running, in_ready low until the final step
module exec_unit
   import exec_unit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ID_W  = DEF_ID_W
) (
   input  logic      clk,
   input  logic      rst_n,
   exec_unit_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH);

   state_t             state;
   state_t             state_nxt;
   logic               accept;
   logic               mul_last;
   logic [WIDTH-1:0]   a_eff;
   logic [WIDTH-1:0]   b_eff;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_step;
   logic [WIDTH-1:0]   mplier;
   logic [CNT_W-1:0]   cnt;
   logic [ID_W-1:0]    mul_dst;

   assign accept = bus.in_valid & bus.in_ready;

   assign a_eff = (bus.wb_en && (bus.wb_id == bus.src1_id)) ? bus.wb_data : bus.a;
   assign b_eff = (bus.wb_en && (bus.wb_id == bus.src2_id)) ? bus.wb_data : bus.b;

   exec_alu #(.WIDTH(WIDTH)) u_alu (
      .op     (bus.op),
      .a      (a_eff),
      .b      (b_eff),
      .result (alu_res),
      .carry  (alu_c)
   );

   assign acc_step = acc + (mplier[0] ? mcand : '0);
   assign mul_last = (state == ST_MUL) && (cnt == '0);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept && (bus.op == OP_MUL)) state_nxt = ST_MUL;
         ST_MUL:  if (cnt == '0) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      bus.in_ready = (state == ST_IDLE);
   end

   // Multiplier datapath. Partial product 0 is folded into the accept edge so the
   // last of the WIDTH steps lands on the edge that makes the result visible
   // WIDTH cycles after accept, with in_ready already back high in that cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand   <= '0;
         acc     <= '0;
         mplier  <= '0;
         cnt     <= '0;
         mul_dst <= '0;
      end else if (accept && (bus.op == OP_MUL)) begin
         mcand   <= {{(WIDTH-1){1'b0}}, a_eff, 1'b0};
         acc     <= b_eff[0] ? {{WIDTH{1'b0}}, a_eff} : '0;
         mplier  <= b_eff >> 1;
         cnt     <= CNT_W'(WIDTH-2);
         mul_dst <= bus.dst_id_in;
      end else if (state == ST_MUL) begin
         mcand  <= mcand << 1;
         acc    <= acc_step;
         mplier <= mplier >> 1;
         cnt    <= cnt - CNT_W'(1);
      end
   end

   // Writeback port and flags; everything but wb_en holds unless a result lands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.wb_en   <= 1'b0;
         bus.wb_id   <= '0;
         bus.wb_data <= '0;
         bus.flag_z  <= 1'b0;
         bus.flag_c  <= 1'b0;
      end else begin
         bus.wb_en <= 1'b0;
         if (mul_last) begin
            bus.wb_en   <= 1'b1;
            bus.wb_id   <= mul_dst;
            bus.wb_data <= acc_step[WIDTH-1:0];
            bus.flag_z  <= (acc_step[WIDTH-1:0] == '0);
            bus.flag_c  <= |acc_step[2*WIDTH-1:WIDTH];
         end else if (accept && is_single_op(bus.op)) begin
            bus.wb_en   <= 1'b1;
            bus.wb_id   <= bus.dst_id_in;
            bus.wb_data <= alu_res;
            bus.flag_z  <= (alu_res == '0);
            bus.flag_c  <= alu_c;
         end
      end
   end

endmodule
